// File: rtl/serial_pkg.sv
// Definitions shared by the UART transmit and receive stages: frame states,
// parity encodings and the 16x oversampling constants.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int         OVERSAMPLE  = 16;
    localparam logic [3:0] MID_SAMPLE  = 4'd7;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    // Index of the last data bit for a size code (size+5 bits, so 4+size).
    function automatic logic [2:0] last_data_bit(input logic [1:0] sz);
        return {1'b1, sz};
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Brings the serial line and the 16x baud strobe into the clk domain and
// turns each rising edge of the strobe into a single-cycle tick.
module rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic brgen,
    input  logic in,
    output logic line,
    output logic tick
);

    logic [1:0] in_q;
    logic [2:0] brgen_q;
    logic       tick_q;

    // The line synchronizer resets to the idle (high) level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q    <= 2'b11;
            brgen_q <= 3'b000;
            tick_q  <= 1'b0;
        end else begin
            in_q    <= {in_q[0], in};
            brgen_q <= {brgen_q[1:0], brgen};
            tick_q  <= brgen_q[1] & ~brgen_q[2];
        end
    end

    assign line = in_q[1];
    assign tick = tick_q;

endmodule

// File: rtl/receiver.sv
// UART receive deframer: oversamples the synchronized line on baud ticks and
// writes each word with its parity/framing flags into the RX FIFO.
module receiver
    import serial_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       brgen,
    input  logic       enable,
    input  logic [1:0] size,
    input  logic       stop2,
    input  logic [1:0] parity,
    input  logic       in,
    input  logic       fifo_full,
    input  logic       clear_overrun,
    output logic       data_write,
    output logic [9:0] data,
    output logic       overrun,
    output logic       busy
);

    logic line;
    logic tick;

    rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .brgen (brgen),
        .in    (in),
        .line  (line),
        .tick  (tick)
    );

    state_t     state_q, state_d;
    logic [3:0] counter_q, counter_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [1:0] size_q, size_d;
    logic [1:0] par_q, par_d;
    logic       stop2_q, stop2_d;
    logic       par_err_q, par_err_d;
    logic       frame_err_q, frame_err_d;
    logic       second_stop_q, second_stop_d;
    logic       armed_q, armed_d;
    logic       data_write_q, data_write_d;
    logic [9:0] data_q, data_d;
    logic       overrun_q, overrun_d;
    logic       frame_bad;
    logic       set_overrun;

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        size_d        = size_q;
        par_d         = par_q;
        stop2_d       = stop2_q;
        par_err_d     = par_err_q;
        frame_err_d   = frame_err_q;
        second_stop_d = second_stop_q;
        armed_d       = armed_q;
        data_write_d  = 1'b0;
        data_d        = data_q;
        frame_bad     = frame_err_q | ~line;
        set_overrun   = 1'b0;

        if (!enable) begin
            state_d   = IDLE;
            counter_d = 4'd0;
            armed_d   = 1'b0;
        end else if (tick) begin
            if (state_q != IDLE) begin
                counter_d = counter_q + 4'd1;
            end
            case (state_q)
                IDLE: begin
                    // Frame format is frozen at start detection.
                    if (line) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d       = START;
                        counter_d     = 4'd0;
                        size_d        = size;
                        par_d         = parity;
                        stop2_d       = stop2;
                        rx_d          = 8'd0;
                        par_err_d     = 1'b0;
                        frame_err_d   = 1'b0;
                        second_stop_d = 1'b0;
                    end
                end
                START: begin
                    if (counter_q == MID_SAMPLE) begin
                        if (line) begin
                            state_d = IDLE;
                        end else begin
                            state_d   = DATA;
                            counter_d = 4'd0;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                DATA: begin
                    if (counter_q == LAST_SAMPLE) begin
                        rx_d[bit_cnt_q] = line;
                        bit_cnt_d       = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == last_data_bit(size_q)) begin
                            state_d = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (counter_q == LAST_SAMPLE) begin
                        if (par_q == PAR_EVEN) begin
                            par_err_d = (line != ^rx_q);
                        end else begin
                            par_err_d = (line != ~^rx_q);
                        end
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (counter_q == LAST_SAMPLE) begin
                        frame_err_d = frame_bad;
                        if (stop2_q && !second_stop_q) begin
                            second_stop_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            // A framing error disarms so a held break yields one word.
                            if (frame_bad) begin
                                armed_d = 1'b0;
                            end
                            if (fifo_full) begin
                                set_overrun = 1'b1;
                            end else begin
                                data_write_d = 1'b1;
                                data_d       = {frame_bad, par_err_q, rx_q};
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (set_overrun) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            counter_q     <= 4'd0;
            bit_cnt_q     <= 3'd0;
            rx_q          <= 8'd0;
            size_q        <= 2'd0;
            par_q         <= PAR_NONE;
            stop2_q       <= 1'b0;
            par_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            second_stop_q <= 1'b0;
            armed_q       <= 1'b0;
            data_write_q  <= 1'b0;
            data_q        <= 10'd0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            size_q        <= size_d;
            par_q         <= par_d;
            stop2_q       <= stop2_d;
            par_err_q     <= par_err_d;
            frame_err_q   <= frame_err_d;
            second_stop_q <= second_stop_d;
            armed_q       <= armed_d;
            data_write_q  <= data_write_d;
            data_q        <= data_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_write = data_write_q;
    assign data       = data_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the UART receiver: frames are built bit by bit from a
// word description, expected words are queued and a monitor checks each write.
module tb_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       brgen;
    logic       enable = 1'b1;
    logic [1:0] size = 2'd3;
    logic       stop2 = 1'b0;
    logic [1:0] parity = 2'd0;
    logic       in_line = 1'b1;
    logic       fifo_full = 1'b0;
    logic       clear_overrun = 1'b0;
    logic       data_write;
    logic [9:0] data;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [1:0] phase = 2'd0;
    logic [9:0] exp_q[$];
    int         exp_write_cyc = -1;
    logic       exp_overrun = 1'b0;

    receiver dut (
        .clk           (clk),
        .reset         (reset),
        .brgen         (brgen),
        .enable        (enable),
        .size          (size),
        .stop2         (stop2),
        .parity        (parity),
        .in            (in_line),
        .fifo_full     (fifo_full),
        .clear_overrun (clear_overrun),
        .data_write    (data_write),
        .data          (data),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Baud strobe: one rising edge every 4 clk cycles.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        phase <= phase + 2'd1;
    end
    assign brgen = phase[1];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every FIFO write must match the oldest expected word.
    always @(negedge clk) begin
        if (data_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=0x%0h required=none", data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("write_data", int'(data), int'(e));
                $display("write data=0x%03h expected=0x%03h at cyc %0d", data, e, cyc);
            end
            if (exp_write_cyc >= 0) begin
                check("write_cycle", cyc, exp_write_cyc);
                exp_write_cyc = -1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to the clk negedge that follows the next brgen rising edge.
    task automatic wait_edge();
        do @(negedge clk); while (phase != 2'd2);
    endtask

    task automatic drive_bit(input logic b);
        in_line = b;
        repeat (16) wait_edge();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] sz, input logic [1:0] par,
                              input logic st2, input logic flip_par, input logic stop_a,
                              input logic stop_b, input logic full, input logic timed);
        int         nbits;
        int         slots;
        int         start_cyc;
        logic [7:0] dm;
        logic       par_en, p_expected, p_sent, pe, fe;
        nbits      = int'(sz) + 5;
        dm         = d & 8'((1 << nbits) - 1);
        par_en     = (par == 2'b01) || (par == 2'b10);
        p_expected = (par == 2'b01) ? ^dm : ~^dm;
        p_sent     = p_expected ^ flip_par;
        pe         = par_en && (p_sent != p_expected);
        fe         = !stop_a || (st2 && !stop_b);
        slots      = 1 + nbits + (par_en ? 1 : 0) + 1 + (st2 ? 1 : 0);
        size      = sz;
        parity    = par;
        stop2     = st2;
        fifo_full = full;
        if (!full) exp_q.push_back({fe, pe, dm});
        else exp_overrun = 1'b1;
        wait_edge();
        start_cyc = cyc;
        if (timed) exp_write_cyc = start_cyc + 4 * (16 * (slots - 1) + 8) + 4;
        $display("frame d=0x%02h bits=%0d par=%0d stop2=%0d flip=%0d stops=%0d%0d full=%0d",
                 dm, nbits, par, st2, flip_par, stop_a, stop_b, full);
        drive_bit(1'b0);
        // Scramble the format controls mid-frame; the receiver must ignore them.
        size   = 2'($urandom);
        parity = 2'($urandom);
        stop2  = 1'($urandom);
        for (int i = 0; i < nbits; i++) drive_bit(dm[i]);
        if (par_en) drive_bit(p_sent);
        drive_bit(stop_a);
        if (st2) drive_bit(stop_b);
        in_line   = 1'b1;
        fifo_full = 1'b0;
        repeat (4) wait_edge();
        check("busy_after_frame", int'(busy), 0);
        check("overrun_after_frame", int'(overrun), int'(exp_overrun));
        if (exp_overrun) begin
            @(negedge clk) clear_overrun = 1'b1;
            @(negedge clk) clear_overrun = 1'b0;
            exp_overrun = 1'b0;
            check("overrun_cleared", int'(overrun), 0);
        end
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check("reset_data_write", int'(data_write), 0);
        check("reset_data", int'(data), 0);
        check("reset_overrun", int'(overrun), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b1;
        repeat (4) wait_edge();

        // 8N1 0xA5 with exact write timing.
        send_frame(8'hA5, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        // 7E1 0x35, good then flipped parity.
        send_frame(8'h35, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 2'd2, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // 5 bits, 2 stop bits, second stop low.
        send_frame(8'h1F, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // False start: low for 4 ticks, back to IDLE on tick 8.
        wait_edge();
        s = cyc;
        in_line = 1'b0;
        repeat (4) wait_edge();
        in_line = 1'b1;
        while (cyc < s + 35) @(negedge clk);
        check("false_start_busy_t7", int'(busy), 1);
        @(negedge clk);
        check("false_start_idle_t8", int'(busy), 0);
        repeat (8) wait_edge();

        // Overrun, then a normal frame.
        send_frame(8'h3C, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h5A, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Enable dropped mid-frame: no write, back to IDLE.
        size = 2'd3; parity = 2'd0; stop2 = 1'b0;
        wait_edge();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        @(negedge clk) enable = 1'b0;
        @(negedge clk);
        check("disable_busy", int'(busy), 0);
        enable  = 1'b1;
        in_line = 1'b1;
        repeat (200) wait_edge();
        check("disable_no_write_pending", exp_q.size(), 0);

        // Break for 40 bit times yields a single framing-error word.
        exp_q.push_back(10'h200);
        wait_edge();
        in_line = 1'b0;
        repeat (40 * 16) wait_edge();
        in_line = 1'b1;
        repeat (8) wait_edge();
        check("break_single_word", exp_q.size(), 0);

        // Asynchronous reset mid-frame, then 0x81.
        wait_edge();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_data", int'(data), 0);
        check("async_reset_write", int'(data_write), 0);
        in_line = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (32) wait_edge();
        check("post_reset_unarmed_busy", int'(busy), 0);
        in_line = 1'b1;
        repeat (4) wait_edge();
        send_frame(8'h81, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Randomized frames against the word model.
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 1'b0);
        end

        repeat (20) wait_edge();
        check("pending_writes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receiver.md
# receiver

Serial receive stage of the UART: it samples the incoming line with the shared 16x baud tick, deframes 5–8 data bits with optional parity and 1 or 2 stop bits, and writes each received word, with its error flags, into the RX FIFO. It is the line-side counterpart of the transmitter. It uses the same `brgen`, `size`, `parity`, `stop2` and `enable` controls, so a looped-back transmitter output is received bit-exact.

## Interface
- No parameters. Oversample ratio and sample points are package constants.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `brgen` in 1 — baud generator output at 16x bit rate. Each rising edge, detected in `clk`, is one tick.
- `enable` in 1 — receiver enable. Low acts as a synchronous return to IDLE.
- `size` in 2 — data bits minus 5 (00 = 5 bits … 11 = 8 bits).
- `stop2` in 1 — 0 = 1 stop bit, 1 = 2 stop bits.
- `parity` in 2 — 00 none, 01 even, 10 odd, 11 treated as none.
- `in` in 1 — serial line, asynchronous, idles high.
- `fifo_full` in 1 — RX FIFO full flag.
- `clear_overrun` in 1 — one-cycle pulse that clears `overrun`.
- `data_write` out 1 — one-cycle FIFO write strobe.
- `data` out 10 — {framing_err, parity_err, rx[7:0]}. Unused high data bits are 0.
- `overrun` out 1 — sticky; set when a word is dropped because the FIFO is full.
- `busy` out 1 — high in any state other than IDLE.

## Operation
- `in` passes through a 2-flop synchronizer. `brgen` passes through a 2-flop synchronizer plus a rising-edge detector, producing `tick`.
- All FSM actions occur only on `tick`. The 4-bit `counter` increments on every tick outside IDLE.
- Start detection latches `size`, `parity` and `stop2`. Changes to them mid-frame have no effect.
- IDLE: on a tick with synced line 0 and `armed`=1, go to START and set counter to 0. A tick with line 1 sets `armed`.
- START: when counter==7 (mid-bit), sample the line.
  - Line 1: false start; return to IDLE.
  - Line 0: counter←0, bit_count←0, go to DATA.
- DATA: when counter==15, sample into rx[bit_count], LSB first, and increment bit_count. After bit size+5 is sampled, go to PARITY if parity is 01 or 10, otherwise go to STOP.
- PARITY: when counter==15, sample.
  - Even: expected = XOR of the received data bits.
  - Odd: expected = XNOR of the received data bits.
  - A mismatch sets parity_err.
- STOP: when counter==15, sample. A 0 sets framing_err. When stop2=1, a second stop bit is sampled 16 ticks later, and either bit being 0 sets framing_err.
- After the final stop sample:
  - fifo_full=0: pulse `data_write` and return to IDLE.
  - fifo_full=1: suppress the write, set `overrun`, and return to IDLE.
- After any framing error, `armed`←0. This prevents a held-low break from producing repeated words: a break yields exactly one all-zero framing-error word.
- `clear_overrun` in the same cycle as a new overrun: set wins.
- `enable`=0: state←IDLE, counter←0, `armed`←0, no write. Registered outputs hold their values.

## Timing
- Reset values: data_write 0, data 0, overrun 0, busy 0, state IDLE, armed 0.
- Sample ticks are counted from the start-detection tick, which is tick 0:
  - start bit: tick 8
  - data bit k: tick 24+16k
  - parity (when enabled): next slot
  - stop bits: following slots
- 8N1 example: last stop bit is sampled at tick 152.
- `data_write` rises in the `clk` cycle after the final-stop tick and lasts exactly 1 cycle. `data` is valid in that cycle and holds until the next write.
- Input latency: line to FSM is 2 `clk` (synchronizer); brgen edge to tick is 3 `clk`.
- Asynchronous reset mid-frame: all outputs reach their reset values immediately with no write. After release, the first start is accepted only after the line has been seen high on a tick.

## Structure
- Shared package `serial_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), shared with the transmitter
  - the parity encoding constants PAR_NONE/PAR_EVEN/PAR_ODD
  - OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15
- One sub-module, `rx_sync`: the 2-flop synchronizers for `in` and `brgen` plus the `tick` edge detector.

## Test plan
- 8N1, 0xA5, FIFO not full → one `data_write` with data=10'h0A5, at tick 152 plus 1 clk. `busy` is low afterwards.
- 7E1, 0x35 with correct parity bit 0 → data=10'h035. The same frame with parity flipped → data=10'h135.
- 5-bit, 2 stop bits, 0x1F with second stop driven low → data=10'h21F (framing_err).
- Line low for 4 ticks, then high → no write, and the FSM returns to IDLE at tick 8.
- fifo_full=1 during an 8N1 frame of 0x3C → no `data_write` and `overrun`=1. A `clear_overrun` pulse clears it, and the next frame is written normally.
- Break: line held low for 40 bit times → exactly one write, data=10'h200. Then assert async reset mid-frame of the next byte, release it, and send 0x81 → only data=10'h081 is written.
